// File: rtl/spike_out_packetizer_pkg.sv
// spike_out_packetizer_pkg: shared widths, packet layout and scan-state encoding.
package spike_out_packetizer_pkg;

    localparam int NUM_NEURONS = 32;
    localparam int NEURON_ID_W = 5;
    localparam int CORE_ID_W   = 8;
    localparam int TS_W        = 8;
    localparam int FIFO_DEPTH  = 16;
    localparam int PKT_W       = CORE_ID_W + TS_W + NEURON_ID_W;

    localparam int NID_LSB  = 0;
    localparam int TS_LSB   = NID_LSB + NEURON_ID_W;
    localparam int CORE_LSB = TS_LSB + TS_W;

    typedef enum logic {IDLE, SCAN} state_t;

    // Lowest-index set bit; returns 0 for an empty vector.
    function automatic logic [NEURON_ID_W-1:0] lowest_set(input logic [NUM_NEURONS-1:0] v);
        lowest_set = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--)
            if (v[i]) lowest_set = NEURON_ID_W'(i);
    endfunction

    function automatic logic [PKT_W-1:0] make_pkt(input logic [CORE_ID_W-1:0] core,
                                                   input logic [TS_W-1:0] ts,
                                                   input logic [NEURON_ID_W-1:0] nid);
        make_pkt = {core, ts, nid};
    endfunction

endpackage

// File: rtl/spike_out_packetizer_if.sv
// spike_out_packetizer_if: spike-vector input link and packet output link of the packetizer.
interface spike_out_packetizer_if;
    import spike_out_packetizer_pkg::*;

    logic [NUM_NEURONS-1:0] spike_vec_i;
    logic                   spike_vld_i;
    logic                   spike_rdy_o;
    logic                   ts_clr_i;
    logic [PKT_W-1:0]       pkt_o;
    logic                   pkt_vld_o;
    logic                   pkt_rdy_i;
    logic                   busy_o;

    modport master (
        input  spike_vec_i, spike_vld_i, ts_clr_i, pkt_rdy_i,
        output spike_rdy_o, pkt_o, pkt_vld_o, busy_o
    );

    modport slave (
        output spike_vec_i, spike_vld_i, ts_clr_i, pkt_rdy_i,
        input  spike_rdy_o, pkt_o, pkt_vld_o, busy_o
    );

endinterface

// File: rtl/spike_out_packetizer_fifo.sv
// spike_pkt_fifo: synchronous FIFO; push ignored when full, pop ignored when empty, no bypass.
module spike_pkt_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign count = cnt_q;
    // Head is forced to zero when empty so the output is clean after reset.
    assign dout  = empty ? '0 : mem_q[rd_q];

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
        cnt_d   = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/spike_out_packetizer.sv
// spike_out_packetizer: scans each accepted spike vector lowest-bit-first into
// {core, timestep, neuron} packets queued in a FIFO towards the router.
module spike_out_packetizer
    import spike_out_packetizer_pkg::*;
#(
    parameter logic [CORE_ID_W-1:0] CORE_ID = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    spike_out_packetizer_if.master bus
);

    state_t                   state_q, state_d;
    logic [NUM_NEURONS-1:0]   pending_q, pending_d;
    logic [TS_W-1:0]          ts_q, ts_d, ts_cur_q, ts_cur_d;
    logic [NEURON_ID_W-1:0]   nid;
    logic [PKT_W-1:0]         pkt_d;
    logic                     accept, push, pop, full, empty;
    logic [$clog2(FIFO_DEPTH):0] count;

    assign bus.spike_rdy_o = (state_q == IDLE) && !rst;
    assign accept          = bus.spike_vld_i && bus.spike_rdy_o;
    assign pop             = bus.pkt_vld_o && bus.pkt_rdy_i;
    assign bus.pkt_vld_o   = !empty;
    assign bus.busy_o      = (state_q == SCAN) || (count != '0);

    always_comb begin
        nid       = lowest_set(pending_q);
        push      = (state_q == SCAN) && !full;
        pkt_d     = make_pkt(CORE_ID, ts_cur_q, nid);
        pending_d = accept ? bus.spike_vec_i
                  : push   ? pending_q & ~(NUM_NEURONS'(1) << nid)
                  : pending_q;
        // A clear coinciding with an accept stamps this vector with 0 and moves on to 1.
        ts_cur_d  = accept ? (bus.ts_clr_i ? '0 : ts_q) : ts_cur_q;
        ts_d      = bus.ts_clr_i ? TS_W'(accept) : accept ? ts_q + 1'b1 : ts_q;
        state_d   = accept ? (|bus.spike_vec_i ? SCAN : IDLE)
                  : (push && pending_d == '0) ? IDLE
                  : state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            ts_q      <= '0;
            ts_cur_q  <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ts_q      <= ts_d;
            ts_cur_q  <= ts_cur_d;
        end
    end

    spike_pkt_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pkt_d),
        .dout  (bus.pkt_o),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_spike_out_packetizer.sv
// tb_spike_out_packetizer: table-driven vectors, directed corner sequences and
// randomized traffic checked against a queue-based packet model.
module tb_spike_out_packetizer;
    import spike_out_packetizer_pkg::*;

    localparam logic [7:0] CID = 8'h3C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spike_out_packetizer_if bus();

    spike_out_packetizer #(.CORE_ID(CID)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [20:0] exp_q[$];
    logic [20:0] log_q[$];
    logic [7:0]  m_ts = '0;
    logic [7:0]  t;
    logic        rnd_rdy = 1'b0;
    logic        hold_prev = 1'b0;
    logic [20:0] prev_pkt = '0;
    logic [20:0] p0, pl;

    typedef struct {
        logic [31:0] vec;
        logic        clr;
        int          n;
        logic [7:0]  ts;
        logic [4:0]  first;
        logic [4:0]  last;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference model: every accepted vector expands to one packet per set bit, ascending.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_ts = '0;
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_vld", 32'(bus.pkt_vld_o), 32'd1);
                check("hold_pkt", 32'(bus.pkt_o), 32'(prev_pkt));
            end
            if (bus.pkt_vld_o && bus.pkt_rdy_i) begin
                log_q.push_back(bus.pkt_o);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_pkt: got 0x%0h expected no packet", bus.pkt_o);
                end else begin
                    check("pkt", 32'(bus.pkt_o), 32'(exp_q.pop_front()));
                end
            end
            if (bus.spike_vld_i && bus.spike_rdy_o) begin
                t = bus.ts_clr_i ? 8'd0 : m_ts;
                for (int n = 0; n < 32; n++)
                    if (bus.spike_vec_i[n]) exp_q.push_back({CID, t, 5'(n)});
                m_ts = t + 8'd1;
            end else if (bus.ts_clr_i) begin
                m_ts = '0;
            end
            hold_prev = bus.pkt_vld_o && !bus.pkt_rdy_i;
            prev_pkt  = bus.pkt_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) bus.pkt_rdy_i = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [31:0] v, input logic clr);
        int k = 0;
        while (!bus.spike_rdy_o && k < 300) begin
            tick();
            k++;
        end
        if (!bus.spike_rdy_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: spike_rdy_o got 0 expected 1");
        end else begin
            bus.spike_vec_i = v;
            bus.spike_vld_i = 1'b1;
            bus.ts_clr_i    = clr;
            tick();
            bus.spike_vld_i = 1'b0;
            bus.ts_clr_i    = 1'b0;
        end
    endtask

    task automatic drain(input int lim);
        int k = 0;
        while (bus.busy_o && k < lim) begin
            tick();
            k++;
        end
        check("drain_idle", 32'(bus.busy_o), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        check("rst_rdy_low", 32'(bus.spike_rdy_o), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_rdy", 32'(bus.spike_rdy_o), 32'd1);
        check("rst_vld", 32'(bus.pkt_vld_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_pkt", 32'(bus.pkt_o), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        bus.spike_vec_i = '0;
        bus.spike_vld_i = 1'b0;
        bus.ts_clr_i    = 1'b0;
        bus.pkt_rdy_i   = 1'b1;

        tbl[0]  = '{32'h0000_0000, 1'b0, 0,  8'd0, 5'd0, 5'd0};
        tbl[1]  = '{32'h0000_0004, 1'b0, 1,  8'd1, 5'd2, 5'd2};
        tbl[2]  = '{32'h8000_0001, 1'b0, 2,  8'd2, 5'd0, 5'd31};
        tbl[3]  = '{32'h0000_0000, 1'b0, 0,  8'd3, 5'd0, 5'd0};
        tbl[4]  = '{32'h0000_0000, 1'b0, 0,  8'd4, 5'd0, 5'd0};
        tbl[5]  = '{32'h0000_0000, 1'b0, 0,  8'd5, 5'd0, 5'd0};
        tbl[6]  = '{32'h0000_0000, 1'b0, 0,  8'd6, 5'd0, 5'd0};
        tbl[7]  = '{32'h0000_0001, 1'b1, 1,  8'd0, 5'd0, 5'd0};
        tbl[8]  = '{32'h0000_0001, 1'b0, 1,  8'd1, 5'd0, 5'd0};
        tbl[9]  = '{32'h0000_F0F0, 1'b0, 8,  8'd2, 5'd4, 5'd15};
        tbl[10] = '{32'hFFFF_FFFF, 1'b0, 32, 8'd3, 5'd0, 5'd31};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            log_q.delete();
            send(tbl[i].vec, tbl[i].clr);
            drain(200);
            check($sformatf("row%0d_count", i), 32'(log_q.size()), 32'(tbl[i].n));
            if (tbl[i].n > 0 && log_q.size() > 0) begin
                p0 = log_q[0];
                pl = log_q[log_q.size() - 1];
                check($sformatf("row%0d_core", i), 32'(p0[20:13]), 32'(CID));
                check($sformatf("row%0d_ts", i), 32'(p0[12:5]), 32'(tbl[i].ts));
                check($sformatf("row%0d_first", i), 32'(p0[4:0]), 32'(tbl[i].first));
                check($sformatf("row%0d_last", i), 32'(pl[4:0]), 32'(tbl[i].last));
            end
        end

        // Accept-to-output latency and ready low time for a two-spike vector.
        do_reset();
        send(32'h8000_0001, 1'b0);
        check("lat_rdy_n1", 32'(bus.spike_rdy_o), 32'd0);
        check("lat_vld_n1", 32'(bus.pkt_vld_o), 32'd0);
        tick();
        check("lat_vld_n2", 32'(bus.pkt_vld_o), 32'd1);
        check("lat_pkt_n2", 32'(bus.pkt_o), 32'({CID, 8'd0, 5'd0}));
        check("lat_rdy_n2", 32'(bus.spike_rdy_o), 32'd0);
        tick();
        check("lat_rdy_n3", 32'(bus.spike_rdy_o), 32'd1);
        check("lat_pkt_n3", 32'(bus.pkt_o), 32'({CID, 8'd0, 5'd31}));
        tick();
        check("lat_vld_n4", 32'(bus.pkt_vld_o), 32'd0);
        check("lat_busy_n4", 32'(bus.busy_o), 32'd0);

        // Full vector against a stalled router: FIFO fills, scan holds, nothing lost.
        do_reset();
        bus.pkt_rdy_i = 1'b0;
        log_q.delete();
        send(32'hFFFF_FFFF, 1'b0);
        repeat (40) tick();
        check("stall_busy", 32'(bus.busy_o), 32'd1);
        check("stall_rdy", 32'(bus.spike_rdy_o), 32'd0);
        check("stall_vld", 32'(bus.pkt_vld_o), 32'd1);
        check("stall_pkt", 32'(bus.pkt_o), 32'({CID, 8'd0, 5'd0}));
        bus.pkt_rdy_i = 1'b1;
        drain(200);
        check("stall_total", 32'(log_q.size()), 32'd32);
        check("stall_left", 32'(exp_q.size()), 32'd0);

        // Timestep wrap after 256 empty vectors.
        do_reset();
        repeat (256) send(32'h0, 1'b0);
        log_q.delete();
        send(32'h2, 1'b0);
        drain(50);
        check("wrap_count", 32'(log_q.size()), 32'd1);
        if (log_q.size() > 0) begin
            p0 = log_q[0];
            check("wrap_ts", 32'(p0[12:5]), 32'd0);
            check("wrap_nid", 32'(p0[4:0]), 32'd1);
        end

        // Reset in the middle of a scan discards everything.
        do_reset();
        send(32'h0, 1'b0);
        bus.pkt_rdy_i = 1'b0;
        send(32'h0000_00FF, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_rdy", 32'(bus.spike_rdy_o), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("mid_vld", 32'(bus.pkt_vld_o), 32'd0);
        check("mid_busy", 32'(bus.busy_o), 32'd0);
        check("mid_rdy", 32'(bus.spike_rdy_o), 32'd1);
        check("mid_pkt", 32'(bus.pkt_o), 32'd0);
        bus.pkt_rdy_i = 1'b1;
        log_q.delete();
        send(32'h1, 1'b0);
        drain(50);
        check("mid_count", 32'(log_q.size()), 32'd1);
        if (log_q.size() > 0) begin
            p0 = log_q[0];
            check("mid_ts", 32'(p0[12:5]), 32'd0);
        end

        // Randomized traffic with random back-pressure, clears and resets.
        do_reset();
        rnd_rdy = 1'b1;
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 3))
                0: v = 32'h0;
                1: v = $urandom;
                2: v = $urandom & $urandom & $urandom;
                default: v = 32'h1 << $urandom_range(0, 31);
            endcase
            send(v, $urandom_range(0, 9) == 0);
            repeat ($urandom_range(0, 3)) tick();
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end
        rnd_rdy = 1'b0;
        bus.pkt_rdy_i = 1'b1;
        drain(3000);
        check("rand_left", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
